// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction encoder. INSTR_ENC_RANGE_CHECK_EN adds a
// per-entry immediate range-error bit to the buffered word.
package instr_enc_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_S = 2'd2,
    FMT_B = 2'd3
  } fmt_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int INSTR_W = 32;
`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam int ERR_W = 1;
`else
  localparam int ERR_W = 0;
`endif

  // Buffered entry = {err (when enabled), addr, instr}
  function automatic int entry_w(input int addr_w);
    return INSTR_W + addr_w + ERR_W;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Generic synchronous FIFO with occupancy count, sync flush and async active-high reset.
module instr_enc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 65,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PTR_W-1:0]        wr_q, rd_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  assign cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);

  // Storage is reset so the head reads zero until the first word lands
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_encoder.sv
// Packs R/I/S/B instruction fields into RV32 words tagged with an imem byte address.
// Define INSTR_ENC_RANGE_CHECK_EN to flag immediates that do not fit in 12 signed bits.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int              DEPTH     = 2,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              err_o
);

  localparam int ENTRY_W = entry_w(ADDR_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [31:0]        word_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   count;
  logic               push, pop;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  always_comb begin
    word_d = '0;
    case (fmt_e'(fmt_i))
      FMT_R: word_d = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word_d = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word_d = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      // imm_i is already the halfword offset, so bit n here is byte-offset bit n+1
      FMT_B: word_d = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i, imm_i[3:0],
                       imm_i[10], opcode_i};
      default: word_d = '0;
    endcase
  end

  // Full FIFO never accepts, even if the head is popping this cycle
  assign in_ready_o = (count < CNT_W'(DEPTH)) & ~flush_i;
  assign push       = in_valid_i & in_ready_o;
  assign pop        = out_valid_o & out_ready_i;

  always_comb begin
    addr_d = addr_q;
    if (flush_i)   addr_d = BASE_ADDR;
    else if (push) addr_d = addr_q + ADDR_W'(4);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) addr_q <= BASE_ADDR;
    else       addr_q <= addr_d;
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic range_err;
  assign range_err = (fmt_e'(fmt_i) != FMT_R) &&
                     (imm_i != {{20{imm_i[11]}}, imm_i[11:0]});
  assign wr_entry  = {range_err, addr_q, word_d};
  assign err_o     = rd_entry[ENTRY_W-1];
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm_i[31:12];
  assign wr_entry      = {addr_q, word_d};
  assign err_o         = 1'b0;
`endif

  assign instr_o = rd_entry[31:0];
  assign addr_o  = rd_entry[32 +: ADDR_W];

  instr_enc_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .data_o  (rd_entry),
    .valid_o (out_valid_o),
    .count_o (count)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (default build, range check disabled).
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = 2'd0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [11:0] bimm;

  instr_encoder #(.DEPTH(2), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .instr_o(instr), .addr_o(addr), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fields(input logic [1:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                        input logic [6:0] fn7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
  endtask

  initial begin
    #3;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    tick(); tick();
    rst = 1'b0;

    // R add x3,x1,x2
    fields(FMT_R, OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    check("r_pre_valid", 64'(out_valid), 64'd0);
    tick(); in_valid = 1'b0;
    check("r_valid", 64'(out_valid), 64'd1);
    check("r_instr", 64'(instr), 64'h002081B3);
    check("r_addr", 64'(addr), 64'(BASE));
    check("r_err", 64'(err), 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("r_popped", 64'(out_valid), 64'd0);

    // I addi x5,x0,-1
    fields(FMT_I, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("i_instr", 64'(instr), 64'hFFF00293);
    check("i_addr", 64'(addr), 64'(BASE + 32'd4));
    check("i_err", 64'(err), 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // B beq x1,x2,+8 bytes
    fields(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("b_instr", 64'(instr), 64'h00208463);
    check("b_addr", 64'(addr), 64'(BASE + 32'd8));
    bimm = {instr[31], instr[7], instr[30:25], instr[11:8]};
    check("b_roundtrip", 64'({{20{bimm[11]}}, bimm}), 64'd4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Backpressure: two stores fill the FIFO, third word (R sub) waits
    fields(FMT_S, OP_STORE, 5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'h24);
    in_valid = 1'b1; tick();
    fields(FMT_S, OP_STORE, 5'd0, 5'd2, 5'd1, 3'd0, 7'd0, 32'hFFFF_FFF8);
    check("bp_ready1", 64'(in_ready), 64'd1);
    tick();
    fields(FMT_R, OP_R, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'd0);
    check("bp_full", 64'(in_ready), 64'd0);
    check("bp_head0", 64'(instr), 64'h02532223);
    check("bp_addr0", 64'(addr), 64'(BASE + 32'hC));
    tick();
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    check("bp_hold_instr", 64'(instr), 64'h02532223);
    out_ready = 1'b1; tick();
    check("bp_head1", 64'(instr), 64'hFE110C23);
    check("bp_addr1", 64'(addr), 64'(BASE + 32'h10));
    check("bp_ready2", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    check("bp_head2", 64'(instr), 64'h409403B3);
    check("bp_addr2", 64'(addr), 64'(BASE + 32'h14));
    check("bp_valid2", 64'(out_valid), 64'd1);
    tick(); out_ready = 1'b0;
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush with two buffered words and a concurrent push attempt
    fields(FMT_I, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1; tick(); tick();
    flush = 1'b1;
    check("fl_ready", 64'(in_ready), 64'd0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    fields(FMT_R, OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("fl_addr", 64'(addr), 64'(BASE));
    check("fl_instr", 64'(instr), 64'h002081B3);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Asynchronous reset mid-cycle with two buffered words
    in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_instr", 64'(instr), 64'd0);
    check("ar_addr", 64'(addr), 64'd0);
    tick(); rst = 1'b0;
    fields(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("ar_next_addr", 64'(addr), 64'(BASE));
    // Out-of-range immediate is truncated; no error flag in this build
    check("rng_imm", 64'(instr[31:20]), 64'h800);
    check("rng_instr", 64'(instr), 64'h80000093);
    check("rng_err", 64'(err), 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("end_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
